// File: rtl/register_right_driver_if.sv
// register_right_driver_if
//   Bundles the request/completion handshake and data lines between the
//   clocked driver and the asynchronous shift-right register.
//   Signals:
//     saveReq  - load request (driver -> register)
//     saveFin  - load completion, asynchronous (register -> driver)
//     rightReq - shift request (driver -> register)
//     rightFin - shift completion, asynchronous (register -> driver)
//     dataOut  - value presented to the register's in port (driver -> register)
//     regOut   - register contents, stable while fin is high (register -> driver)
//   Modports: master = clocked driver, slave = asynchronous register.
interface register_right_driver_if #(
  parameter int Width = 32
) ();
  logic             saveReq;
  logic             saveFin;
  logic             rightReq;
  logic             rightFin;
  logic [Width-1:0] dataOut;
  logic [Width-1:0] regOut;

  modport master (
    output saveReq, rightReq, dataOut,
    input  saveFin, rightFin, regOut
  );

  modport slave (
    input  saveReq, rightReq, dataOut,
    output saveFin, rightFin, regOut
  );
endinterface

// File: rtl/register_right_driver.sv
// register_right_driver
//   Synchronous initiator for the asynchronous shift-right register. On an
//   accepted start it loads loadValue into the register, issues
//   min(shiftCount, Width) right shifts, captures the register output and
//   pulses done. A fin that fails to arrive within TimeoutCycles aborts the
//   command and sets the sticky timeoutErr.
//   Ports:
//     clk, rst    - clock, synchronous active-high reset
//     start       - command strobe, honoured only when idle
//     loadValue   - value to load
//     shiftCount  - number of right shifts (saturates at Width)
//     busy        - command in progress
//     done        - one-cycle pulse, result valid
//     timeoutErr  - sticky handshake timeout flag
//     result      - captured register output
//     regBus      - handshake/data bundle towards the register (master side)
module register_right_driver #(
  parameter int Width         = 32,
  parameter int CntWidth      = 6,
  parameter int SyncStages    = 2,
  parameter int SettleCycles  = 2,
  parameter int TimeoutCycles = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [Width-1:0]    loadValue,
  input  logic [CntWidth-1:0] shiftCount,
  output logic                busy,
  output logic                done,
  output logic                timeoutErr,
  output logic [Width-1:0]    result,
  register_right_driver_if.master regBus
);

  localparam int SettleW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam int WaitW   = $clog2(TimeoutCycles + 1);

  localparam logic [SettleW-1:0]  SettleLast  = SettleW'(SettleCycles - 1);
  localparam logic [WaitW-1:0]    TimeoutLast = WaitW'(TimeoutCycles - 1);
  localparam logic [WaitW-1:0]    FlushCycles = WaitW'(SyncStages);
  localparam logic [CntWidth-1:0] MaxShifts   = CntWidth'(Width);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SAVE_REQ   = 4'd1,
    SAVE_WAIT  = 4'd2,
    SAVE_REL   = 4'd3,
    SHIFT_REQ  = 4'd4,
    SHIFT_WAIT = 4'd5,
    SHIFT_REL  = 4'd6,
    CAPTURE    = 4'd7,
    DONE       = 4'd8,
    ERROR      = 4'd9
  } state_t;

  state_t                state_r;
  logic [SyncStages-1:0] saveSync_r;
  logic [SyncStages-1:0] rightSync_r;
  logic [SettleW-1:0]    settleCnt_r;
  logic [WaitW-1:0]      waitCnt_r;
  logic                  relCnt_r;
  logic [CntWidth-1:0]   remaining_r;
  logic                  saveReq_r;
  logic                  rightReq_r;
  logic [Width-1:0]      dataOut_r;
  logic [CntWidth-1:0]   cmdShifts_s;
  logic                  waitFin_s;

  assign regBus.saveReq  = saveReq_r;
  assign regBus.rightReq = rightReq_r;
  assign regBus.dataOut  = dataOut_r;

  // Bring the asynchronous fin levels into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      saveSync_r  <= {SyncStages{1'b0}};
      rightSync_r <= {SyncStages{1'b0}};
    end else begin
      saveSync_r  <= {saveSync_r[SyncStages-2:0], regBus.saveFin};
      rightSync_r <= {rightSync_r[SyncStages-2:0], regBus.rightFin};
    end
  end

  // Saturate the requested shift count at the data width.
  always_comb begin
    cmdShifts_s = shiftCount;
    if (shiftCount > MaxShifts) begin
      cmdShifts_s = MaxShifts;
    end else begin
      cmdShifts_s = shiftCount;
    end
  end

  // Pick the synchronized fin belonging to the operation being waited on.
  always_comb begin
    waitFin_s = 1'b0;
    if (state_r == SAVE_WAIT) begin
      waitFin_s = saveSync_r[SyncStages-1];
    end else begin
      waitFin_s = rightSync_r[SyncStages-1];
    end
  end

  // Command sequencer: load, shift loop, capture and handshake timeout.
  // Every output is assigned here so all of them come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      settleCnt_r <= {SettleW{1'b0}};
      waitCnt_r   <= {WaitW{1'b0}};
      relCnt_r    <= 1'b0;
      remaining_r <= {CntWidth{1'b0}};
      saveReq_r   <= 1'b0;
      rightReq_r  <= 1'b0;
      dataOut_r   <= {Width{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      timeoutErr  <= 1'b0;
      result      <= {Width{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            dataOut_r   <= loadValue;
            remaining_r <= cmdShifts_s;
            timeoutErr  <= 1'b0;
            busy        <= 1'b1;
            saveReq_r   <= 1'b1;
            settleCnt_r <= {SettleW{1'b0}};
            state_r     <= SAVE_REQ;
          end
        end

        SAVE_REQ, SHIFT_REQ: begin
          // fin briefly drops after a req rise; hold off looking at it
          // until the settle window has passed.
          if (settleCnt_r == SettleLast) begin
            settleCnt_r <= {SettleW{1'b0}};
            waitCnt_r   <= {WaitW{1'b0}};
            state_r     <= (state_r == SAVE_REQ) ? SAVE_WAIT : SHIFT_WAIT;
          end else begin
            settleCnt_r <= settleCnt_r + 1'b1;
          end
        end

        SAVE_WAIT, SHIFT_WAIT: begin
          // The synchronizer still carries samples from the masked window
          // for SyncStages cycles; only trust sfin once those have drained.
          if (waitFin_s && (waitCnt_r >= FlushCycles)) begin
            saveReq_r  <= 1'b0;
            rightReq_r <= 1'b0;
            relCnt_r   <= 1'b0;
            state_r    <= (state_r == SAVE_WAIT) ? SAVE_REL : SHIFT_REL;
          end else if (waitCnt_r == TimeoutLast) begin
            saveReq_r  <= 1'b0;
            rightReq_r <= 1'b0;
            busy       <= 1'b0;
            timeoutErr <= 1'b1;
            state_r    <= ERROR;
          end else begin
            waitCnt_r <= waitCnt_r + 1'b1;
          end
        end

        SAVE_REL: begin
          // Two low cycles guarantee a distinct next rising edge.
          if (relCnt_r) begin
            if (remaining_r == {CntWidth{1'b0}}) begin
              state_r <= CAPTURE;
            end else begin
              rightReq_r  <= 1'b1;
              settleCnt_r <= {SettleW{1'b0}};
              state_r     <= SHIFT_REQ;
            end
          end else begin
            relCnt_r <= 1'b1;
          end
        end

        SHIFT_REL: begin
          if (relCnt_r) begin
            remaining_r <= remaining_r - 1'b1;
            if (remaining_r == {{(CntWidth-1){1'b0}}, 1'b1}) begin
              state_r <= CAPTURE;
            end else begin
              rightReq_r  <= 1'b1;
              settleCnt_r <= {SettleW{1'b0}};
              state_r     <= SHIFT_REQ;
            end
          end else begin
            relCnt_r <= 1'b1;
          end
        end

        CAPTURE: begin
          // regOut has been quiet for several cycles since the last fin.
          result  <= regBus.regOut;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= DONE;
        end

        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end

        ERROR: begin
          state_r <= IDLE;
        end

        default: begin
          saveReq_r  <= 1'b0;
          rightReq_r <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_right_driver.sv
module tb_register_right_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] loadValue = 32'd0;
  logic [5:0]  shiftCount = 6'd0;
  logic        busy, done, timeoutErr;
  logic [31:0] result;

  register_right_driver_if #(.Width(32)) regBus ();

  register_right_driver #(
    .Width(32), .CntWidth(6), .SyncStages(2), .SettleCycles(2), .TimeoutCycles(255)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .loadValue(loadValue),
    .shiftCount(shiftCount), .busy(busy), .done(done),
    .timeoutErr(timeoutErr), .result(result), .regBus(regBus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural asynchronous register: fin drops on req rise, 3 ns later the
  // operation completes and fin rises (unless told never to respond).
  logic [31:0] regVal = 32'd0;
  bit rightRespond = 1'b1;
  int saveCount = 0;
  int rightCount = 0;
  initial begin
    regBus.saveFin  = 1'b1;
    regBus.rightFin = 1'b1;
    regBus.regOut   = 32'd0;
  end

  always @(posedge regBus.saveReq) begin
    saveCount++;
    regBus.saveFin = 1'b0;
    #3;
    regVal = regBus.dataOut;
    regBus.regOut = regVal;
    regBus.saveFin = 1'b1;
  end

  always @(posedge regBus.rightReq) begin
    rightCount++;
    regBus.rightFin = 1'b0;
    #3;
    if (rightRespond) begin
      regVal = regVal >> 1;
      regBus.regOut = regVal;
      regBus.rightFin = 1'b1;
    end
  end

  // Request-shape monitor: overlap of the two reqs and low gap between shifts.
  int  overlap = 0;
  int  minGap = 1000;
  int  lowRun = 0;
  bit  seenRight = 1'b0;
  logic prevRight = 1'b0;
  always @(negedge clk) begin
    if (regBus.saveReq && regBus.rightReq) overlap++;
    if (regBus.rightReq) begin
      if (!prevRight && seenRight && lowRun < minGap) minGap = lowRun;
      seenRight = 1'b1;
      lowRun = 0;
    end else begin
      lowRun++;
    end
    prevRight = regBus.rightReq;
  end

  // Reference: a load followed by min(n, 32) logical right shifts.
  function automatic logic [31:0] expResult(input logic [31:0] lv, input int n);
    int s;
    s = (n > 32) ? 32 : n;
    if (s >= 32) return 32'd0;
    return lv >> s;
  endfunction

  function automatic int expShifts(input int n);
    return (n > 32) ? 32 : n;
  endfunction

  task automatic run_cmd(input logic [31:0] lv, input logic [5:0] sc,
                         output bit gotDone, output bit gotErr,
                         output logic busySeen, output int cycles);
    @(negedge clk);
    saveCount = 0; rightCount = 0; overlap = 0; minGap = 1000; seenRight = 1'b0;
    start = 1'b1; loadValue = lv; shiftCount = sc;
    @(negedge clk);
    start = 1'b0;
    busySeen = busy;
    gotDone = 1'b0; gotErr = 1'b0; cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cycles++;
      if (done) begin gotDone = 1'b1; break; end
      if (timeoutErr) begin gotErr = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, timeoutErr, regBus.saveReq, regBus.rightReq} !== 5'b0 ||
        result !== 32'd0 || regBus.dataOut !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b sreq=%b rreq=%b result=%h dout=%h expected all zero",
               busy, done, timeoutErr, regBus.saveReq, regBus.rightReq, result, regBus.dataOut);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_only();
    bit d, e; logic b; int c;
    run_cmd(32'hA5A5_F00F, 6'd0, d, e, b, c);
    checks++;
    if (d !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL load_only_done got done=%b busy=%b expected done=1 busy=0", d, busy);
    end
    checks++;
    if (result !== 32'hA5A5_F00F) begin
      failures++; $display("FAIL load_only_result got %h expected a5a5f00f", result);
    end
    checks++;
    if (saveCount != 1 || rightCount != 0) begin
      failures++; $display("FAIL load_only_pulses got save=%0d right=%0d expected 1/0", saveCount, rightCount);
    end
  endtask

  task automatic test_three_shifts();
    bit d, e; logic b; int c;
    run_cmd(32'h8000_0001, 6'd3, d, e, b, c);
    checks++;
    if (b !== 1'b1) begin
      failures++; $display("FAIL three_busy_after_start got %b expected 1", b);
    end
    checks++;
    if (d !== 1'b1 || busy !== 1'b0 || result !== 32'h1000_0000) begin
      failures++; $display("FAIL three_result got done=%b busy=%b result=%h expected 1/0/10000000", d, busy, result);
    end
    checks++;
    if (saveCount != 1 || rightCount != 3 || minGap < 2 || overlap != 0) begin
      failures++; $display("FAIL three_pulses got save=%0d right=%0d gap=%0d overlap=%0d expected 1/3/>=2/0",
                           saveCount, rightCount, minGap, overlap);
    end
  endtask

  task automatic test_saturation();
    bit d, e; logic b; int c;
    run_cmd(32'hFFFF_FFFF, 6'd40, d, e, b, c);
    checks++;
    if (d !== 1'b1 || result !== 32'd0 || rightCount != 32) begin
      failures++; $display("FAIL saturation got done=%b result=%h right=%0d expected 1/00000000/32", d, result, rightCount);
    end
  endtask

  task automatic test_random();
    bit d, e; logic b; int c;
    logic [31:0] lv; logic [5:0] sc;
    for (int k = 0; k < 8; k++) begin
      lv = $urandom;
      sc = 6'($urandom_range(0, 63));
      run_cmd(lv, sc, d, e, b, c);
      checks++;
      if (d !== 1'b1 || result !== expResult(lv, int'(sc)) ||
          rightCount != expShifts(int'(sc)) || saveCount != 1 || overlap != 0) begin
        failures++;
        $display("FAIL random_%0d lv=%h sc=%0d got done=%b result=%h right=%0d save=%0d overlap=%0d expected result=%h right=%0d",
                 k, lv, sc, d, result, rightCount, saveCount, overlap, expResult(lv, int'(sc)), expShifts(int'(sc)));
      end
    end
  endtask

  task automatic test_timeout();
    bit d, e; logic b; int c;
    logic [31:0] prevResult;
    prevResult = result;
    rightRespond = 1'b0;
    run_cmd(32'h1234_5678, 6'd2, d, e, b, c);
    checks++;
    if (e !== 1'b1 || d !== 1'b0 || c < 255) begin
      failures++; $display("FAIL timeout_flag got err=%b done=%b cycles=%0d expected 1/0/>=255", e, d, c);
    end
    checks++;
    if (regBus.saveReq !== 1'b0 || regBus.rightReq !== 1'b0 || busy !== 1'b0 || result !== prevResult) begin
      failures++; $display("FAIL timeout_idle got sreq=%b rreq=%b busy=%b result=%h expected 0/0/0/%h",
                           regBus.saveReq, regBus.rightReq, busy, result, prevResult);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (timeoutErr !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky got %b expected 1", timeoutErr);
    end
    rightRespond = 1'b1;
    regBus.rightFin = 1'b1;
    run_cmd(32'hF0F0_0F0F, 6'd4, d, e, b, c);
    checks++;
    if (d !== 1'b1 || timeoutErr !== 1'b0 || result !== 32'h0F0F_00F0) begin
      failures++; $display("FAIL timeout_recover got done=%b err=%b result=%h expected 1/0/0f0f00f0", d, timeoutErr, result);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit d, e; logic b; int c;
    bit hit;
    @(negedge clk);
    saveCount = 0; rightCount = 0;
    start = 1'b1; loadValue = 32'hDEAD_BEEF; shiftCount = 6'd5;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rightCount == 2 && regBus.rightReq) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL reset_mid_reach got right=%0d expected second shift in flight", rightCount);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (regBus.saveReq !== 1'b0 || regBus.rightReq !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      failures++; $display("FAIL reset_mid_outputs got sreq=%b rreq=%b busy=%b done=%b result=%h expected all zero",
                           regBus.saveReq, regBus.rightReq, busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    run_cmd(32'hC000_0003, 6'd5, d, e, b, c);
    checks++;
    if (d !== 1'b1 || result !== 32'h0600_0000 || rightCount != 5) begin
      failures++; $display("FAIL reset_mid_fresh got done=%b result=%h right=%0d expected 1/06000000/5", d, result, rightCount);
    end
  endtask

  task automatic test_start_ignored();
    bit d, hit;
    @(negedge clk);
    saveCount = 0; rightCount = 0;
    start = 1'b1; loadValue = 32'h0000_FF00; shiftCount = 6'd4;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (regBus.rightReq) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    start = 1'b1; loadValue = 32'h1111_1111; shiftCount = 6'd1;
    @(negedge clk);
    start = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done) begin d = 1'b1; break; end
    end
    checks++;
    if (!hit || !d || result !== 32'h0000_0FF0 || saveCount != 1 || rightCount != 4) begin
      failures++; $display("FAIL start_ignored got reached=%b done=%b result=%h save=%0d right=%0d expected 1/1/00000ff0/1/4",
                           hit, d, result, saveCount, rightCount);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || saveCount != 1) begin
      failures++; $display("FAIL start_ignored_idle got busy=%b save=%0d expected 0/1", busy, saveCount);
    end
  endtask

  task automatic test_back_to_back();
    int nDone;
    @(negedge clk);
    saveCount = 0; rightCount = 0;
    start = 1'b1; loadValue = 32'h0000_0006; shiftCount = 6'd1;
    nDone = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        nDone++;
        checks++;
        if (result !== 32'h0000_0003 || busy !== 1'b0) begin
          failures++; $display("FAIL held_start_result got result=%h busy=%b expected 00000003/0", result, busy);
        end
        if (nDone == 2) break;
      end
    end
    start = 1'b0;
    checks++;
    if (nDone != 2 || saveCount != 2 || overlap != 0) begin
      failures++; $display("FAIL held_start_count got dones=%0d saves=%0d overlap=%0d expected 2/2/0", nDone, saveCount, overlap);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_three_shifts();
    test_saturation();
    test_random();
    test_timeout();
    test_reset_mid_shift();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
